// File: rtl/seg_scan_display.sv
// Eight-digit common-anode hex scanner. New data is staged and committed only
// at frame boundaries, so a frame never mixes old and new digits.
module seg_scan_display #(
  parameter int CLK_DIV  = 100000,
  parameter int DIGITS   = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data_In,
  input  logic        Load,
  input  logic [7:0]  Dp_In,
  input  logic        Blank,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        Pending,
  output logic        Frame_Done
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [2:0]     IDX_MAX = 3'(DIGITS - 1);

  // Active-low {g..a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [31:0]   act_data_r;
  logic [7:0]    act_dp_r;
  logic [31:0]   pend_data_r;
  logic [7:0]    pend_dp_r;
  logic          pending_r;
  logic          frame_done_r;
  logic [7:0]    an_r;
  logic [7:0]    seg_r;

  logic          slot_end_s;
  logic          wrap_s;
  logic [3:0]    nib_s;
  logic          upper_zero_s;
  logic [7:0]    an_nxt_s;
  logic [7:0]    seg_nxt_s;

  // Slot/frame boundary detection and next output pattern from current state.
  always_comb begin
    slot_end_s   = (cnt_r == CNT_MAX);
    wrap_s       = slot_end_s && (idx_r == IDX_MAX);
    nib_s        = act_data_r[{idx_r, 2'b00} +: 4];
    // Digit idx is a leading zero when it and every higher nibble are zero.
    upper_zero_s = ((act_data_r >> {idx_r, 2'b00}) == 32'd0);
    if ((cnt_r == {CW{1'b0}}) || Blank ||
        (BLANK_LZ && (idx_r != 3'd0) && upper_zero_s)) begin
      an_nxt_s = 8'hFF;
    end else begin
      an_nxt_s = ~(8'd1 << idx_r);
    end
    seg_nxt_s = {~act_dp_r[idx_r], hex_to_seg(nib_s)};
  end

  // Prescaler and digit index.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= 3'd0;
    end else if (slot_end_s) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= (idx_r == IDX_MAX) ? 3'd0 : idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Pending stage and frame-boundary commit; a Load on the wrap edge bypasses staging.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      act_data_r  <= 32'd0;
      act_dp_r    <= 8'd0;
      pend_data_r <= 32'd0;
      pend_dp_r   <= 8'd0;
      pending_r   <= 1'b0;
    end else if (wrap_s) begin
      pending_r <= 1'b0;
      if (Load) begin
        act_data_r <= Data_In;
        act_dp_r   <= Dp_In;
      end else if (pending_r) begin
        act_data_r <= pend_data_r;
        act_dp_r   <= pend_dp_r;
      end else begin
        act_data_r <= act_data_r;
        act_dp_r   <= act_dp_r;
      end
    end else if (Load) begin
      pend_data_r <= Data_In;
      pend_dp_r   <= Dp_In;
      pending_r   <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      an_r         <= 8'hFF;
      seg_r        <= 8'hFF;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      frame_done_r <= wrap_s;
    end
  end

  assign AN         = an_r;
  assign SEG        = seg_r;
  assign Pending    = pending_r;
  assign Frame_Done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a cycle-count based behavioural model checked
// every cycle, plus hand-computed literal checks on key display slots.
module tb_seg_scan_display;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Data_In = 32'd0;
  logic        Load = 1'b0;
  logic [7:0]  Dp_In = 8'd0;
  logic        Blank = 1'b0;
  logic [7:0]  AN, SEG, AN2, SEG2;
  logic        Pending, Frame_Done, Pending2, Frame_Done2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seg_scan_display #(.CLK_DIV(4), .DIGITS(8), .BLANK_LZ(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Load(Load), .Dp_In(Dp_In),
    .Blank(Blank), .AN(AN), .SEG(SEG), .Pending(Pending), .Frame_Done(Frame_Done));

  seg_scan_display #(.CLK_DIV(4), .DIGITS(8), .BLANK_LZ(1'b0)) dut_nolz (
    .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Load(Load), .Dp_In(Dp_In),
    .Blank(Blank), .AN(AN2), .SEG(SEG2), .Pending(Pending2), .Frame_Done(Frame_Done2));

  always #5 Clk = ~Clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: time since reset release plus the committed and staged values.
  int          m_tick;
  logic [31:0] m_act, m_pend;
  logic [7:0]  m_act_dp, m_pend_dp;
  logic        m_pending;
  logic [7:0]  exp_an = 8'hFF, exp_an2 = 8'hFF, exp_seg = 8'hFF;
  logic        exp_fd = 1'b0;

  function automatic logic [7:0] exp_anodes(int c, int d, logic [31:0] v, logic bl, bit lz);
    bit hidden;
    hidden = 1'b0;
    if (lz && d > 0) begin
      hidden = 1'b1;
      for (int k = d; k < 8; k++)
        if (((v >> (4 * k)) & 32'hF) != 32'd0) hidden = 1'b0;
    end
    if (c == 0 || bl || hidden) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic [7:0] exp_segs(int d, logic [31:0] v, logic [7:0] dp);
    logic [31:0] nib;
    nib = (v >> (4 * d)) & 32'hF;
    return {~dp[d], hex_tab[nib[3:0]]};
  endfunction

  always @(posedge Clk or negedge Reset) begin
    int c, d;
    bit wr;
    if (!Reset) begin
      m_tick <= 0; m_act <= 32'd0; m_act_dp <= 8'd0; m_pend <= 32'd0; m_pend_dp <= 8'd0;
      m_pending <= 1'b0; exp_an <= 8'hFF; exp_an2 <= 8'hFF; exp_seg <= 8'hFF; exp_fd <= 1'b0;
    end else begin
      c  = m_tick % 4;
      d  = (m_tick / 4) % 8;
      wr = ((m_tick % 32) == 31);
      exp_an  <= exp_anodes(c, d, m_act, Blank, 1'b1);
      exp_an2 <= exp_anodes(c, d, m_act, Blank, 1'b0);
      exp_seg <= exp_segs(d, m_act, m_act_dp);
      exp_fd  <= wr;
      if (wr && Load) begin
        m_act <= Data_In; m_act_dp <= Dp_In; m_pending <= 1'b0;
      end else if (wr) begin
        if (m_pending) begin m_act <= m_pend; m_act_dp <= m_pend_dp; end
        m_pending <= 1'b0;
      end else if (Load) begin
        m_pend <= Data_In; m_pend_dp <= Dp_In; m_pending <= 1'b1;
      end
      m_tick <= m_tick + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("AN", {24'd0, AN}, {24'd0, exp_an});
      chk("SEG", {24'd0, SEG}, {24'd0, exp_seg});
      chk("Pending", {31'd0, Pending}, {31'd0, m_pending});
      chk("Frame_Done", {31'd0, Frame_Done}, {31'd0, exp_fd});
      chk("AN_nolz", {24'd0, AN2}, {24'd0, exp_an2});
      chk("SEG_nolz", {24'd0, SEG2}, {24'd0, exp_seg});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Advance to the negedge where Frame_Done is seen high (state = tick 0 of a frame).
  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge Clk);
    while (Frame_Done !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_fd: Frame_Done not seen within 100 cycles");
    end
  endtask

  task automatic load_val(input logic [31:0] v, input logic [7:0] dp);
    Data_In = v; Dp_In = dp; Load = 1'b1;
    step(1);
    Load = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    #1 Reset = 1'b0;
    chk_en = 1'b1;
    step(3);
    Reset = 1'b1;
    step(20);

    // Mid-frame load: staged until the wrap, then digit0 'd', digit7 '1'.
    wait_fd();
    step(10);
    load_val(32'h1234ABCD, 8'h00);
    chk("lit_pending_set", {31'd0, Pending}, 32'd1);
    wait_fd();
    chk("lit_pending_clr", {31'd0, Pending}, 32'd0);
    step(2);
    chk("lit_d0_seg", {24'd0, SEG}, 32'hA1);
    chk("lit_d0_an", {24'd0, AN}, 32'hFE);
    step(28);
    chk("lit_d7_seg", {24'd0, SEG}, 32'hF9);
    chk("lit_d7_an", {24'd0, AN}, 32'h7F);

    // Two loads in one frame: last wins.
    wait_fd();
    step(5);
    load_val(32'h11, 8'h00);
    step(5);
    load_val(32'h22, 8'h00);
    wait_fd();
    step(6);
    chk("lit_last_wins_seg", {24'd0, SEG}, 32'hA4);
    chk("lit_last_wins_an", {24'd0, AN}, 32'hFD);

    // Load exactly on the wrap edge bypasses the pending stage.
    wait_fd();
    step(31);
    load_val(32'h5, 8'h00);
    chk("lit_wrap_fd", {31'd0, Frame_Done}, 32'd1);
    chk("lit_wrap_pending", {31'd0, Pending}, 32'd0);
    step(2);
    chk("lit_wrap_seg", {24'd0, SEG}, 32'h92);

    // Leading-zero blanking of 0x00000F00.
    load_val(32'h00000F00, 8'h00);
    wait_fd();
    step(10);
    chk("lit_lz_d2", {24'd0, AN}, 32'hFB);
    step(4);
    chk("lit_lz_d3", {24'd0, AN}, 32'hFF);
    chk("lit_lz_d3_nolz", {24'd0, AN2}, 32'hF7);

    // Value zero: only digit 0 lit when blanking is enabled.
    load_val(32'h0, 8'h00);
    wait_fd();
    step(2);
    chk("lit_zero_seg", {24'd0, SEG}, 32'hC0);
    chk("lit_zero_an", {24'd0, AN}, 32'hFE);
    step(28);
    chk("lit_zero_d7", {24'd0, AN}, 32'hFF);
    chk("lit_zero_d7_nolz", {24'd0, AN2}, 32'h7F);

    // Decimal point on a blanked digit does not light it.
    load_val(32'h1, 8'h80);
    wait_fd();
    step(2);
    chk("lit_dp_d0_seg", {24'd0, SEG}, 32'hF9);
    step(28);
    chk("lit_dp_d7_an", {24'd0, AN}, 32'hFF);

    // Blank for 10 cycles; frame pulses keep their cadence.
    load_val(32'h87654321, 8'h00);
    wait_fd();
    fd_cnt = 0;
    for (int i = 1; i <= 64; i++) begin
      Blank = (i >= 5 && i < 15);
      @(negedge Clk);
      if (i == 10) chk("lit_blank_an", {24'd0, AN}, 32'hFF);
      if (Frame_Done) fd_cnt++;
    end
    Blank = 1'b0;
    chk("lit_blank_fd_count", fd_cnt, 32'd2);

    // Asynchronous reset mid-frame drops the pending value immediately.
    wait_fd();
    step(6);
    load_val(32'hDEADBEEF, 8'hFF);
    step(3);
    #2 Reset = 1'b0;
    #1;
    chk("lit_rst_an", {24'd0, AN}, 32'hFF);
    chk("lit_rst_seg", {24'd0, SEG}, 32'hFF);
    chk("lit_rst_pending", {31'd0, Pending}, 32'd0);
    chk("lit_rst_fd", {31'd0, Frame_Done}, 32'd0);
    step(2);
    Reset = 1'b1;
    step(40);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      Load    = ($urandom_range(0, 19) == 0);
      Data_In = $urandom >> (4 * $urandom_range(0, 8));
      Dp_In   = 8'($urandom);
      Blank   = ($urandom_range(0, 15) == 0);
      @(negedge Clk);
    end
    Load = 1'b0;
    Blank = 1'b0;
    step(4);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
